// File: rtl/motion_line_renderer.sv
// Motion-object line renderer: clears the back line-RAM half, then draws every sprite hitting next_row.
// Optional build macro MOTION_COLLISION_EN adds occupancy tracking with collision / collision_mask outputs.

module motion_line_renderer #(
  parameter int  NUM_SPRITES = 8,
  parameter int  LINE_DEPTH  = 256,
  localparam int IW          = $clog2(NUM_SPRITES)
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_n,
  input  logic                   line_start,
  input  logic [9:0]             next_row,
  input  logic                   bank,
  input  logic                   tbl_write,
  input  logic [IW+1:0]          tbl_addr,
  input  logic [11:0]            tbl_wr_data,
  output logic [11:0]            tbl_rd_data,
  output logic [5:0]             rom_sprite_num,
  output logic [2:0]             rom_row,
  output logic [2:0]             rom_col,
  input  logic [1:0]             rom_pixel,
  output logic                   lr_write,
  output logic [10:0]            lr_write_addr,
  output logic [1:0]             lr_wr_data,
  output logic                   busy,
  output logic                   overrun,
  input  logic                   overrun_clr,
  output logic                   collision,
  output logic [NUM_SPRITES-1:0] collision_mask
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    SCAN  = 3'd2,
    DRAW  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state_r, state_next;

  logic [NUM_SPRITES-1:0] en_r;
  logic [5:0]             num_r [NUM_SPRITES];
  logic [9:0]             x_r   [NUM_SPRITES];
  logic [9:0]             y_r   [NUM_SPRITES];

  logic [IW-1:0] tbl_idx_s;
  logic [1:0]    tbl_field_s;

  logic          bank_r;
  logic [9:0]    row_lat_r;
  logic [7:0]    clr_cnt_r;
  logic [IW-1:0] idx_r;
  logic [3:0]    draw_cnt_r;
  logic [2:0]    row_r;
  logic [8:0]    base_r;
  logic [5:0]    snum_r;

  logic [9:0]    dy_s;
  logic          hit_s;
  logic          last_clr_s;
  logic [9:0]    pix_addr_s;
  logic          draw_wr_s;

  logic          lr_write_s, lr_write_r;
  logic [10:0]   lr_addr_s, lr_addr_r;
  logic [1:0]    lr_data_s, lr_data_r;
  logic          busy_r;
  logic          overrun_r;
  logic          unused_bits_s;

  assign tbl_idx_s   = tbl_addr[IW+1:2];
  assign tbl_field_s = tbl_addr[1:0];

  assign dy_s       = row_lat_r - y_r[idx_r];
  assign hit_s      = en_r[idx_r] && (dy_s[9:4] == 6'd0);
  assign last_clr_s = (clr_cnt_r == 8'(LINE_DEPTH - 1));
  // ROM data for column k-1 arrives during draw cycle k, so the write address trails by one.
  assign pix_addr_s = {1'b0, base_r} + {6'd0, draw_cnt_r} - 10'd1;
  assign draw_wr_s  = (state_r == DRAW) && (draw_cnt_r != 4'd0) && (rom_pixel != 2'd0) &&
                      (pix_addr_s < 10'(LINE_DEPTH)) && !line_start;

  assign unused_bits_s = ^{tbl_wr_data[11:10], dy_s[0]};

  // Sprite attribute table storage, written by the CPU.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      en_r <= '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        num_r[i] <= 6'd0;
        x_r[i]   <= 10'd0;
        y_r[i]   <= 10'd0;
      end
    end else if (tbl_write) begin
      case (tbl_field_s)
        2'd0: begin
          en_r[tbl_idx_s]  <= tbl_wr_data[6];
          num_r[tbl_idx_s] <= tbl_wr_data[5:0];
        end
        2'd1:    x_r[tbl_idx_s] <= tbl_wr_data[9:0];
        2'd2:    y_r[tbl_idx_s] <= tbl_wr_data[9:0];
        default: ;
      endcase
    end
  end

  // Table readback mux.
  always_comb begin
    tbl_rd_data = 12'd0;
    case (tbl_field_s)
      2'd0:    tbl_rd_data = {5'd0, en_r[tbl_idx_s], num_r[tbl_idx_s]};
      2'd1:    tbl_rd_data = {2'd0, x_r[tbl_idx_s]};
      2'd2:    tbl_rd_data = {2'd0, y_r[tbl_idx_s]};
      default: tbl_rd_data = 12'd0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next;
    end
  end

  // FSM next state; a line_start in any state restarts the clear.
  always_comb begin
    state_next = state_r;
    if (line_start) begin
      state_next = CLEAR;
    end else begin
      case (state_r)
        IDLE:    state_next = IDLE;
        CLEAR:   state_next = last_clr_s ? SCAN : CLEAR;
        SCAN: begin
          if (hit_s) begin
            state_next = DRAW;
          end else if (idx_r == '0) begin
            state_next = DONE;
          end else begin
            state_next = SCAN;
          end
        end
        DRAW: begin
          if (draw_cnt_r != 4'd8) begin
            state_next = DRAW;
          end else if (idx_r == '0) begin
            state_next = DONE;
          end else begin
            state_next = SCAN;
          end
        end
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Per-pass datapath: latched row/bank, clear counter, table index, draw context.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      bank_r     <= 1'b0;
      row_lat_r  <= 10'd0;
      clr_cnt_r  <= 8'd0;
      idx_r      <= '0;
      draw_cnt_r <= 4'd0;
      row_r      <= 3'd0;
      base_r     <= 9'd0;
      snum_r     <= 6'd0;
    end else if (line_start) begin
      bank_r    <= bank;
      row_lat_r <= next_row;
      clr_cnt_r <= 8'd0;
    end else begin
      case (state_r)
        CLEAR: begin
          clr_cnt_r <= clr_cnt_r + 8'd1;
          idx_r     <= IW'(NUM_SPRITES - 1);
        end
        SCAN: begin
          if (hit_s) begin
            draw_cnt_r <= 4'd0;
            row_r      <= dy_s[3:1];
            base_r     <= x_r[idx_r][9:1];
            snum_r     <= num_r[idx_r];
          end else if (idx_r != '0) begin
            idx_r <= idx_r - IW'(1);
          end
        end
        DRAW: begin
          draw_cnt_r <= draw_cnt_r + 4'd1;
          if (draw_cnt_r == 4'd8 && idx_r != '0) begin
            idx_r <= idx_r - IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Line RAM write request for this cycle.
  always_comb begin
    lr_write_s = 1'b0;
    lr_addr_s  = 11'd0;
    lr_data_s  = 2'd0;
    if (state_r == CLEAR && !line_start) begin
      lr_write_s = 1'b1;
      lr_addr_s  = {2'b00, bank_r, clr_cnt_r};
      lr_data_s  = 2'd0;
    end else if (draw_wr_s) begin
      lr_write_s = 1'b1;
      lr_addr_s  = {2'b00, bank_r, pix_addr_s[7:0]};
      lr_data_s  = rom_pixel;
    end else begin
      lr_write_s = 1'b0;
    end
  end

  // Registered outputs: line RAM port, busy, sticky overrun (set beats clear).
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      lr_write_r <= 1'b0;
      lr_addr_r  <= 11'd0;
      lr_data_r  <= 2'd0;
      busy_r     <= 1'b0;
      overrun_r  <= 1'b0;
    end else begin
      lr_write_r <= lr_write_s;
      lr_addr_r  <= lr_addr_s;
      lr_data_r  <= lr_data_s;
      busy_r     <= (state_next != IDLE);
      if (line_start && state_r != IDLE) begin
        overrun_r <= 1'b1;
      end else if (overrun_clr) begin
        overrun_r <= 1'b0;
      end
    end
  end

  assign lr_write       = lr_write_r;
  assign lr_write_addr  = lr_addr_r;
  assign lr_wr_data     = lr_data_r;
  assign busy           = busy_r;
  assign overrun        = overrun_r;
  assign rom_sprite_num = (state_r == DRAW) ? snum_r : 6'd0;
  assign rom_row        = row_r;
  assign rom_col        = draw_cnt_r[2:0];

`ifdef MOTION_COLLISION_EN
  logic [LINE_DEPTH-1:0]  occ_r;
  logic                   coll_r;
  logic [NUM_SPRITES-1:0] mask_r;
  logic                   coll_hit_s;

  assign coll_hit_s = draw_wr_s && occ_r[pix_addr_s[7:0]];

  // Occupancy of the current line plus sticky collision flags.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      occ_r  <= '0;
      coll_r <= 1'b0;
      mask_r <= '0;
    end else begin
      if (state_r == CLEAR && !line_start) begin
        occ_r[clr_cnt_r] <= 1'b0;
      end
      if (draw_wr_s) begin
        occ_r[pix_addr_s[7:0]] <= 1'b1;
      end
      if (coll_hit_s) begin
        coll_r <= 1'b1;
        mask_r <= (overrun_clr ? '0 : mask_r) | (NUM_SPRITES'(1) << idx_r);
      end else if (overrun_clr) begin
        coll_r <= 1'b0;
        mask_r <= '0;
      end
    end
  end

  assign collision      = coll_r;
  assign collision_mask = mask_r;
`else
  assign collision      = 1'b0;
  assign collision_mask = '0;
`endif

endmodule

// File: tb/tb_motion_line_renderer.sv
// Self-checking bench for motion_line_renderer: a sprite-list reference model predicts each rendered line.
// Collision checks depend on MOTION_COLLISION_EN matching the RTL build.

module tb_motion_line_renderer;

  localparam int NS = 8;
  localparam int LD = 256;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          line_start = 1'b0;
  logic [9:0]    next_row = 10'd0;
  logic          bank = 1'b0;
  logic          tbl_write = 1'b0;
  logic [4:0]    tbl_addr = 5'd0;
  logic [11:0]   tbl_wr_data = 12'd0;
  logic [11:0]   tbl_rd_data;
  logic [5:0]    rom_sprite_num;
  logic [2:0]    rom_row;
  logic [2:0]    rom_col;
  logic [1:0]    rom_pixel = 2'd0;
  logic          lr_write;
  logic [10:0]   lr_write_addr;
  logic [1:0]    lr_wr_data;
  logic          busy;
  logic          overrun;
  logic          overrun_clr = 1'b0;
  logic          collision;
  logic [NS-1:0] collision_mask;

  always #5 clk = ~clk;

  motion_line_renderer #(.NUM_SPRITES(NS), .LINE_DEPTH(LD)) dut (
    .i_Clk(clk), .i_Rst_n(rst_n), .line_start(line_start), .next_row(next_row), .bank(bank),
    .tbl_write(tbl_write), .tbl_addr(tbl_addr), .tbl_wr_data(tbl_wr_data), .tbl_rd_data(tbl_rd_data),
    .rom_sprite_num(rom_sprite_num), .rom_row(rom_row), .rom_col(rom_col), .rom_pixel(rom_pixel),
    .lr_write(lr_write), .lr_write_addr(lr_write_addr), .lr_wr_data(lr_wr_data),
    .busy(busy), .overrun(overrun), .overrun_clr(overrun_clr),
    .collision(collision), .collision_mask(collision_mask)
  );

  // Sprite ROM model with one cycle of latency.
  logic [1:0] rom_mem [0:4095];
  always @(posedge clk) rom_pixel <= rom_mem[{rom_sprite_num, rom_row, rom_col}];

  // Line RAM model fed by the DUT's write port; each entry remembers which pass wrote it.
  logic [1:0]  ram [0:511];
  int          stamp [0:511];
  int          pass_id = 0;
  int          seen_pass = 0;
  int          wr_total = 0;
  int          bad_total = 0;
  logic [10:0] first_addr = 11'd0;
  logic [1:0]  first_data = 2'd0;

  always @(negedge clk) begin
    if (rst_n && lr_write) begin
      if (lr_write_addr[10:9] != 2'd0) bad_total++;
      ram[lr_write_addr[8:0]]   = lr_wr_data;
      stamp[lr_write_addr[8:0]] = pass_id;
      wr_total++;
      if (seen_pass != pass_id) begin
        seen_pass  = pass_id;
        first_addr = lr_write_addr;
        first_data = lr_wr_data;
      end
    end
  end

  logic       sh_en  [NS];
  logic [5:0] sh_num [NS];
  logic [9:0] sh_x   [NS];
  logic [9:0] sh_y   [NS];

  int checks = 0;
  int errors = 0;
  int w0 = 0;
  int bad0 = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tbl_wr(input logic [4:0] a, input logic [11:0] d);
    @(negedge clk);
    tbl_write = 1'b1; tbl_addr = a; tbl_wr_data = d;
    @(negedge clk);
    tbl_write = 1'b0;
  endtask

  // Writes all three fields, with junk in the unused high bits.
  task automatic set_entry(input int i, input logic en, input logic [5:0] num,
                           input logic [9:0] x, input logic [9:0] y);
    logic [2:0] ii;
    ii = 3'(i);
    tbl_wr({ii, 2'd0}, {5'($urandom), en, num});
    tbl_wr({ii, 2'd1}, {2'($urandom), x});
    tbl_wr({ii, 2'd2}, {2'($urandom), y});
    sh_en[i] = en; sh_num[i] = num; sh_x[i] = x; sh_y[i] = y;
  endtask

  task automatic clear_table();
    for (int i = 0; i < NS; i++) set_entry(i, 1'b0, 6'd0, 10'd0, 10'd0);
  endtask

  task automatic make_opaque(input logic [5:0] num);
    for (int k = 0; k < 64; k++) rom_mem[{num, 6'(k)}] = 2'(1 + (k % 3));
  endtask

  task automatic start_pass(input logic b, input logic [9:0] row, input logic clr);
    @(negedge clk);
    #1;
    pass_id++;
    w0 = wr_total; bad0 = bad_total;
    line_start = 1'b1; bank = b; next_row = row; overrun_clr = clr;
    @(negedge clk);
    line_start = 1'b0; overrun_clr = 1'b0;
  endtask

  // Paints the expected line from the sprite list (index 0 last, so it wins) and compares.
  task automatic finish_pass(input logic b, input logic [9:0] row);
    logic [1:0]  ex [LD];
    logic [9:0]  dy;
    logic [2:0]  r;
    logic [1:0]  p;
    int          hits, nz, cyc, mism, base, a, own, oth;
    hits = 0; nz = 0; mism = 0;
    for (int j = 0; j < LD; j++) ex[j] = 2'd0;
    for (int i = NS - 1; i >= 0; i--) begin
      dy = row - sh_y[i];
      if (sh_en[i] && dy < 10'd16) begin
        hits++;
        r = dy[3:1];
        base = int'(sh_x[i]) / 2;
        for (int k = 0; k < 8; k++) begin
          p = rom_mem[{sh_num[i], r, 3'(k)}];
          a = base + k;
          if (p != 2'd0 && a < LD) begin
            ex[a] = p;
            nz++;
          end
        end
      end
    end
    cyc = 0;
    while (busy === 1'b1 && cyc < 3000) begin
      cyc++;
      @(negedge clk);
    end
    chk("busy_cycles", 32'(cyc), 32'(LD + NS + 9 * hits + 1));
    repeat (2) @(negedge clk);
    for (int j = 0; j < LD; j++) begin
      own = (b ? 256 : 0) + j;
      oth = (b ? 0 : 256) + j;
      if (stamp[own] != pass_id || ram[own] !== ex[j]) mism++;
      if (stamp[oth] == pass_id) mism++;
    end
    chk("line_ram", 32'(mism), 32'd0);
    chk("write_count", 32'(wr_total - w0), 32'(LD + nz));
    chk("bad_addr", 32'(bad_total - bad0), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  logic [11:0] exp_rd;
  logic        ren;
  logic [9:0]  rrow;
  int          cyc;

  initial begin
    for (int k = 0; k < 4096; k++) rom_mem[k] = 2'($urandom);
    for (int i = 0; i < NS; i++) begin
      sh_en[i] = 1'b0; sh_num[i] = 6'd0; sh_x[i] = 10'd0; sh_y[i] = 10'd0;
    end

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_lr_write", 32'(lr_write), 32'd0);
    chk("rst_lr_data", 32'(lr_wr_data), 32'd0);
    chk("rst_collision", 32'(collision), 32'd0);
    chk("rst_mask", 32'(collision_mask), 32'd0);
    tbl_addr = {3'd5, 2'd1};
    #1 chk("rst_tbl", 32'(tbl_rd_data), 32'd0);
    rst_n = 1'b1;

    // Table write / readback, reserved field ignored
    for (int i = 0; i < NS; i++) begin
      set_entry(i, 1'($urandom), 6'($urandom), 10'($urandom), 10'($urandom));
      tbl_wr({3'(i), 2'd3}, 12'hFFF);
    end
    for (int i = 0; i < NS; i++) begin
      for (int f = 0; f < 4; f++) begin
        @(negedge clk);
        tbl_addr = {3'(i), 2'(f)};
        case (f)
          0:       exp_rd = {5'd0, sh_en[i], sh_num[i]};
          1:       exp_rd = {2'd0, sh_x[i]};
          2:       exp_rd = {2'd0, sh_y[i]};
          default: exp_rd = 12'd0;
        endcase
        #1 chk("tbl_readback", 32'(tbl_rd_data), 32'(exp_rd));
      end
    end
    clear_table();

    // All disabled: pure clear of bank 1
    start_pass(1'b1, 10'd77, 1'b0);
    finish_pass(1'b1, 10'd77);
    chk("clear_first_addr", 32'(first_addr), 32'h100);

    // Single sprite, row 3 of sprite 1 at base 50
    set_entry(0, 1'b1, 6'd1, 10'd100, 10'd40);
    start_pass(1'b0, 10'd46, 1'b0);
    finish_pass(1'b0, 10'd46);

    // Priority: sprite 3 drawn first, sprite 0 on top
    set_entry(3, 1'b1, 6'd2, 10'd100, 10'd40);
    start_pass(1'b1, 10'd46, 1'b0);
    finish_pass(1'b1, 10'd46);
`ifndef MOTION_COLLISION_EN
    chk("collision_off", 32'(collision), 32'd0);
    chk("mask_off", 32'(collision_mask), 32'd0);
`endif

    // Right edge: base 253, only three pixels land
    clear_table();
    make_opaque(6'd7);
    set_entry(2, 1'b1, 6'd7, 10'd506, 10'd40);
    start_pass(1'b0, 10'd41, 1'b0);
    finish_pass(1'b0, 10'd41);

    // Overrun: restart mid-DRAW, then clear
    clear_table();
    set_entry(0, 1'b1, 6'd9, 10'd20, 10'd100);
    start_pass(1'b0, 10'd100, 1'b0);
    cyc = 0;
    while (rom_sprite_num !== 6'd9 && cyc < 600) begin
      cyc++;
      @(negedge clk);
    end
    chk("reach_draw", 32'(rom_sprite_num), 32'd9);
    repeat (3) @(negedge clk);
    start_pass(1'b1, 10'd100, 1'b0);
    chk("overrun_set", 32'(overrun), 32'd1);
    finish_pass(1'b1, 10'd100);
    chk("restart_addr", 32'(first_addr), 32'h100);
    chk("restart_data", 32'(first_data), 32'd0);
    @(negedge clk); overrun_clr = 1'b1;
    @(negedge clk); overrun_clr = 1'b0;
    chk("overrun_clr", 32'(overrun), 32'd0);

    // Set beats clear in the same cycle
    start_pass(1'b0, 10'd100, 1'b0);
    repeat (10) @(negedge clk);
    start_pass(1'b0, 10'd100, 1'b1);
    chk("overrun_set_wins", 32'(overrun), 32'd1);
    finish_pass(1'b0, 10'd100);
    @(negedge clk); overrun_clr = 1'b1;
    @(negedge clk); overrun_clr = 1'b0;
    chk("overrun_clr2", 32'(overrun), 32'd0);

`ifdef MOTION_COLLISION_EN
    // Overlapping opaque sprites 0 and 1
    clear_table();
    make_opaque(6'd5);
    make_opaque(6'd6);
    chk("coll_cleared", 32'(collision), 32'd0);
    set_entry(0, 1'b1, 6'd5, 10'd60, 10'd200);
    set_entry(1, 1'b1, 6'd6, 10'd64, 10'd200);
    start_pass(1'b0, 10'd200, 1'b0);
    finish_pass(1'b0, 10'd200);
    chk("collision", 32'(collision), 32'd1);
    chk("collision_mask", 32'(collision_mask), 32'h01);
    @(negedge clk); overrun_clr = 1'b1;
    @(negedge clk); overrun_clr = 1'b0;
    chk("collision_clr", 32'(collision), 32'd0);
`endif

    // Randomised sprite tables
    for (int it = 0; it < 6; it++) begin
      rrow = 10'($urandom);
      for (int i = 0; i < NS; i++) begin
        ren = 1'($urandom);
        set_entry(i, ren, 6'($urandom), 10'($urandom), 10'(rrow - 10'($urandom_range(0, 23))));
      end
      start_pass(1'($urandom), rrow, 1'b0);
      finish_pass(bank, rrow);
    end

    // Asynchronous reset mid-pass
    start_pass(1'b0, 10'd5, 1'b0);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_lr_write", 32'(lr_write), 32'd0);
    tbl_addr = {3'd2, 2'd1};
    #1 chk("midreset_tbl", 32'(tbl_rd_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
